div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div_if.sv | 21 ++
 rtl/div.sv | 110 +++++++++++
 tb/tb_div.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Operand/result bundle between the EX stage and the iterative divider.
// The EX stage drives the master side; the divider is the slave.
interface div_if;
    logic        signed_div_input;
    logic [31:0] opdata1_input;
    logic [31:0] opdata2_input;
    logic        start_input;
    logic        annul_input;
    logic [63:0] result_output;
    logic        ready_output;

    modport master (
        output signed_div_input, opdata1_input, opdata2_input, start_input, annul_input,
        input  result_output, ready_output
    );

    modport slave (
        input  signed_div_input, opdata1_input, opdata2_input, start_input, annul_input,
        output result_output, ready_output
    );
endinterface

// File: rtl/div.sv
// 32-bit restoring divider, one quotient bit per cycle, signed (DIV) or unsigned (DIVU).
// The result is packed as {remainder, quotient}, which maps to {HI, LO}.
module div (
    input  logic clock,
    input  logic reset,
    div_if.slave bus
);
    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t      state;
    logic [5:0]  counter;
    logic [32:0] partial;
    logic [31:0] quotient;
    logic [31:0] divisor;
    logic        signed_mode;
    logic        dividend_neg;
    logic        divisor_neg;

    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic [31:0] final_q;
    logic [31:0] final_r;

    // Magnitudes are taken modulo 2^32, so -2^31 stays 0x80000000 when read unsigned.
    always_comb begin
        op1_abs = bus.opdata1_input;
        op2_abs = bus.opdata2_input;
        if (bus.signed_div_input && bus.opdata1_input[31])
            op1_abs = ~bus.opdata1_input + 32'd1;
        if (bus.signed_div_input && bus.opdata2_input[31])
            op2_abs = ~bus.opdata2_input + 32'd1;

        shifted = {partial[31:0], quotient[31]};
        diff    = {1'b0, shifted} - {2'b00, divisor};

        final_q = quotient;
        final_r = partial[31:0];
        if (signed_mode && (dividend_neg ^ divisor_neg))
            final_q = ~quotient + 32'd1;
        if (signed_mode && dividend_neg)
            final_r = ~partial[31:0] + 32'd1;
    end

    // The quotient register starts out holding the dividend; its MSBs shift into the
    // partial remainder while quotient bits shift in at the LSB.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= FREE;
            counter           <= 6'd0;
            partial           <= 33'd0;
            quotient          <= 32'd0;
            divisor           <= 32'd0;
            signed_mode       <= 1'b0;
            dividend_neg      <= 1'b0;
            divisor_neg       <= 1'b0;
            bus.result_output <= 64'd0;
            bus.ready_output  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    bus.result_output <= 64'd0;
                    bus.ready_output  <= 1'b0;
                    if (bus.start_input && !bus.annul_input) begin
                        quotient     <= op1_abs;
                        divisor      <= op2_abs;
                        partial      <= 33'd0;
                        counter      <= 6'd0;
                        signed_mode  <= bus.signed_div_input;
                        dividend_neg <= bus.signed_div_input & bus.opdata1_input[31];
                        divisor_neg  <= bus.signed_div_input & bus.opdata2_input[31];
                        state        <= (bus.opdata2_input == 32'd0) ? BY_ZERO : ON;
                    end
                end
                BY_ZERO: begin
                    bus.result_output <= 64'd0;
                    bus.ready_output  <= 1'b1;
                    state             <= END;
                end
                ON: begin
                    if (bus.annul_input) begin
                        bus.result_output <= 64'd0;
                        bus.ready_output  <= 1'b0;
                        state             <= FREE;
                    end else if (counter == 6'd32) begin
                        bus.result_output <= {final_r, final_q};
                        bus.ready_output  <= 1'b1;
                        state             <= END;
                    end else begin
                        // A borrow out of the 33-bit subtraction means the divisor did not fit.
                        partial  <= diff[33] ? shifted : diff[32:0];
                        quotient <= {quotient[30:0], ~diff[33]};
                        counter  <= counter + 6'd1;
                    end
                end
                END: begin
                    if (!bus.start_input) begin
                        bus.result_output <= 64'd0;
                        bus.ready_output  <= 1'b0;
                        state             <= FREE;
                    end
                end
                default: begin
                    state <= FREE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus randomized divides compared
// against plain integer arithmetic.
module tb_div;
    logic clock;
    logic reset;
    int   checkCount;
    int   passCount;

    div_if bus ();

    div dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
        checkCount++;
        if (got === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
    endtask

    // Reference: truncating integer division on 64-bit values, wrapped to 32-bit fields.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0)
            return 64'd0;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic waitReady(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!bus.ready_output && cycles < 100);
    endtask

    // Full transaction: request, latency, result, hold while start is high, release.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          cycles;
        logic [63:0] expected;
        int          expLatency;
        expected   = refDiv(sgn, a, b);
        expLatency = (b == 32'd0) ? 2 : 34;
        bus.signed_div_input = sgn;
        bus.opdata1_input    = a;
        bus.opdata2_input    = b;
        bus.annul_input      = 1'b0;
        bus.start_input      = 1'b1;
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
            if (cycles == 1) begin
                bus.signed_div_input = ~sgn;
                bus.opdata1_input    = $urandom;
                bus.opdata2_input    = $urandom;
            end
        end while (!bus.ready_output && cycles < 100);
        checkOutput({tag, " latency"}, 64'(cycles), 64'(expLatency));
        checkOutput({tag, " result"}, bus.result_output, expected);
        bus.annul_input = 1'b1;
        repeat (3) @(negedge clock);
        bus.annul_input = 1'b0;
        checkOutput({tag, " hold"}, {bus.result_output, 63'd0, bus.ready_output}, {expected, 64'd1});
        bus.start_input = 1'b0;
        @(negedge clock);
        checkOutput({tag, " release"}, {bus.result_output, 63'd0, bus.ready_output}, 128'd0);
    endtask

    initial begin
        int          cycles;
        int          readySeen;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;

        checkCount = 0;
        passCount  = 0;
        reset                = 1'b1;
        bus.signed_div_input = 1'b0;
        bus.opdata1_input    = 32'd0;
        bus.opdata2_input    = 32'd0;
        bus.start_input      = 1'b0;
        bus.annul_input      = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset ready", 64'(bus.ready_output), 64'd0);
        checkOutput("reset result", bus.result_output, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        applyStimulus(1'b0, 32'd100, 32'd7, "udiv 100/7");
        checkOutput("udiv 100/7 const", refDiv(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, "sdiv -7/2");
        applyStimulus(1'b1, 32'h12345678, 32'd0, "div by zero");
        applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, "sdiv overflow");
        applyStimulus(1'b1, 32'h80000000, 32'd3, "sdiv min/3");
        applyStimulus(1'b0, 32'h80000000, 32'hFFFFFFFF, "udiv big");

        // Annul at step 10; the request must vanish without ready ever rising.
        bus.signed_div_input = 1'b0;
        bus.opdata1_input    = 32'h12345678;
        bus.opdata2_input    = 32'd3;
        bus.start_input      = 1'b1;
        repeat (11) @(negedge clock);
        bus.annul_input = 1'b1;
        @(negedge clock);
        checkOutput("annul ready", 64'(bus.ready_output), 64'd0);
        bus.annul_input = 1'b0;
        bus.start_input = 1'b0;
        readySeen = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.ready_output) readySeen++;
        end
        checkOutput("annul never ready", 64'(readySeen), 64'd0);
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, "after annul");

        // Reset mid-divide and again while holding a finished result.
        bus.signed_div_input = 1'b0;
        bus.opdata1_input    = 32'd1000;
        bus.opdata2_input    = 32'd10;
        bus.start_input      = 1'b1;
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1 checkOutput("reset midON", {bus.result_output, 63'd0, bus.ready_output}, 128'd0);
        @(negedge clock);
        reset = 1'b0;
        waitReady(cycles);
        checkOutput("restart latency", 64'(cycles), 64'd34);
        checkOutput("restart result", bus.result_output, 64'd100);
        #2 reset = 1'b1;
        #1 checkOutput("reset in END", {bus.result_output, 63'd0, bus.ready_output}, 128'd0);
        @(negedge clock);
        reset           = 1'b0;
        bus.start_input = 1'b0;
        @(negedge clock);
        checkOutput("idle after reset", 64'(bus.ready_output), 64'd0);

        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = ~32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            applyStimulus(sgn, a, b, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
